// File: rtl/instr_sequencer_pkg.sv
// Shared ISA definitions for the fetch sequencer and the decoder.
package instr_sequencer_pkg;

    // OPR opcodes
    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;
    localparam logic [3:0] OP_JIN = 4'h3;
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_BBL = 4'hC;

    // Machine-cycle phases
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X3 = 3'd7;

    typedef enum logic [0:0] {
        StFetch1,
        StFetch2
    } seq_state_e;

    // True when the first word announces a second ROM word.
    function automatic logic is_two_word(input logic [3:0] opr, input logic [3:0] opa);
        logic two;
        two = 1'b0;
        case (opr)
            OP_JCN, OP_JUN, OP_JMS, OP_ISZ: two = 1'b1;
            OP_FIM:                         two = ~opa[0];  // odd opa is SRC
            OP_JIN:                         two = 1'b0;     // FIN/JIN are single-word
            default:                        two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Fetch-side bus between rom/pc/decoder and the instruction sequencer.
interface instr_sequencer_if #(
    parameter int unsigned AddrW = 12
) ();
    logic [2:0]       cycle;
    logic [3:0]       rom_data;
    logic [AddrW-1:0] pc_addr;
    logic             cond_taken;
    logic [3:0]       opr;
    logic [3:0]       opa;
    logic [3:0]       opr2;
    logic [3:0]       opa2;
    logic             second_word;
    logic             instr_valid;
    logic             pc_load;
    logic [AddrW-1:0] pc_new;
    logic             stack_ovf;

    modport master (
        output cycle, rom_data, pc_addr, cond_taken,
        input  opr, opa, opr2, opa2, second_word, instr_valid, pc_load, pc_new, stack_ovf
    );

    modport slave (
        input  cycle, rom_data, pc_addr, cond_taken,
        output opr, opa, opr2, opa2, second_word, instr_valid, pc_load, pc_new, stack_ovf
    );
endinterface

// File: rtl/instr_sequencer_addr_stack.sv
// Circular subroutine return-address stack with sticky overflow flag.
module addr_stack #(
    parameter int unsigned Depth = 3,
    parameter int unsigned Width = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] push_data_i,
    output logic [Width-1:0] pop_data_o,
    output logic             ovf_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q, ptr_d, ptr_inc, ptr_dec;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             full;

    // Wrapping pointer neighbours and pop read (pop reads the slot below ptr).
    always_comb begin
        ptr_inc    = (ptr_q == PtrMax) ? '0 : ptr_q + PtrW'(1);
        ptr_dec    = (ptr_q == '0) ? PtrMax : ptr_q - PtrW'(1);
        full       = (cnt_q == CntW'(Depth));
        pop_data_o = mem_q[ptr_dec];
        ovf_o      = ovf_q;
    end

    // Next pointer/count/overflow; a full push overwrites the oldest entry.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_i) begin
            ptr_d = ptr_inc;
            if (full) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_i) begin
            ptr_d = ptr_dec;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CntW'(1);
            end
        end
    end

    // Stack state and storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (push_i) begin
                mem_q[ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction-fetch sequencer: assembles OPR/OPA nibbles, tracks two-word
// instructions and drives pc loads for JUN/JMS/JCN/ISZ/BBL.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned StackDepth = 3,
    parameter int unsigned AddrW      = 12
) (
    input logic               clk,
    input logic               rst_n,
    instr_sequencer_if.slave  bus
);
    seq_state_e       state_q, state_d;
    logic [3:0]       opr_q, opa_q, opr2_q, opa2_q;
    logic [AddrW-9:0] pg_q;
    logic [AddrW-1:0] ret_q;
    // Set once a first word has been latched; blocks pulses from a partial fetch.
    logic             started_q;

    logic             at_m1, at_m2, at_x3, two_word;
    logic             push, pop;
    logic [AddrW-1:0] stack_top;
    logic             stack_ovf;
    logic             instr_valid, pc_load;
    logic             stack_ovf_unused;
    logic [AddrW-1:0] pc_new;

    assign at_m1    = (bus.cycle == CYC_M1);
    assign at_m2    = (bus.cycle == CYC_M2);
    assign at_x3    = (bus.cycle == CYC_X3);
    assign two_word = is_two_word(opr_q, opa_q);
    assign stack_ovf_unused = 1'b0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: word boundaries fall on the X3 edge.
    always_comb begin
        state_d = state_q;
        if (at_x3) begin
            unique case (state_q)
                StFetch1: if (started_q && two_word) state_d = StFetch2;
                StFetch2: state_d = StFetch1;
                default:  state_d = StFetch1;
            endcase
        end
    end

    // Outputs at X3: completion pulse, pc load target and stack operation.
    always_comb begin
        instr_valid = 1'b0;
        pc_load     = 1'b0;
        pc_new      = '0;
        push        = 1'b0;
        pop         = 1'b0;
        if (at_x3) begin
            unique case (state_q)
                StFetch1: begin
                    if (started_q && !two_word) begin
                        instr_valid = 1'b1;
                        if (opr_q == OP_BBL) begin
                            pop     = 1'b1;
                            pc_load = 1'b1;
                            pc_new  = stack_top;
                        end
                    end
                end
                StFetch2: begin
                    instr_valid = 1'b1;
                    case (opr_q)
                        OP_JUN: begin
                            pc_load = 1'b1;
                            pc_new  = AddrW'({opa_q, opr2_q, opa2_q});
                        end
                        OP_JMS: begin
                            push    = 1'b1;
                            pc_load = 1'b1;
                            pc_new  = AddrW'({opa_q, opr2_q, opa2_q});
                        end
                        OP_JCN, OP_ISZ: begin
                            if (bus.cond_taken) begin
                                pc_load = 1'b1;
                                pc_new  = {pg_q, opr2_q, opa2_q};
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Nibble latches plus page/return address captured at the second word's M1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opr_q     <= '0;
            opa_q     <= '0;
            opr2_q    <= '0;
            opa2_q    <= '0;
            pg_q      <= '0;
            ret_q     <= '0;
            started_q <= 1'b0;
        end else begin
            if (at_m1) begin
                if (state_q == StFetch1) begin
                    opr_q     <= bus.rom_data;
                    opr2_q    <= '0;
                    opa2_q    <= '0;
                    started_q <= 1'b1;
                end else begin
                    opr2_q <= bus.rom_data;
                    pg_q   <= bus.pc_addr[AddrW-1:8];
                    ret_q  <= bus.pc_addr + AddrW'(1);
                end
            end
            if (at_m2) begin
                if (state_q == StFetch1) begin
                    opa_q <= bus.rom_data;
                end else begin
                    opa2_q <= bus.rom_data;
                end
            end
        end
    end

    addr_stack #(
        .Depth (StackDepth),
        .Width (AddrW)
    ) u_addr_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (ret_q),
        .pop_data_o  (stack_top),
        .ovf_o       (stack_ovf)
    );

    assign bus.opr         = opr_q;
    assign bus.opa         = opa_q;
    assign bus.opr2        = opr2_q;
    assign bus.opa2        = opa2_q;
    assign bus.second_word = (state_q == StFetch2);
    assign bus.instr_valid = instr_valid;
    assign bus.pc_load     = pc_load;
    assign bus.pc_new      = pc_new;
    assign bus.stack_ovf   = stack_ovf | stack_ovf_unused;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench: instruction-level model with a queue-based return stack.
module tb_instr_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_sequencer_if #(.AddrW(12)) bus ();

    instr_sequencer #(
        .StackDepth (3),
        .AddrW      (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference state: program counter, return stack (back = top), overflow flag.
    logic [11:0] pc;
    logic [11:0] stk[$];
    logic        ovf_m;

    // Observations from the last machine cycle.
    logic        ob_valid, ob_load, ob_sw3, ob_stray;
    logic [11:0] ob_new;
    logic [3:0]  ob_opr, ob_opa, ob_opr2, ob_opa2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_opr"},   bus.opr, 0);
        check_eq({tag, "_opa"},   bus.opa, 0);
        check_eq({tag, "_opr2"},  bus.opr2, 0);
        check_eq({tag, "_opa2"},  bus.opa2, 0);
        check_eq({tag, "_sw"},    bus.second_word, 0);
        check_eq({tag, "_valid"}, bus.instr_valid, 0);
        check_eq({tag, "_load"},  bus.pc_load, 0);
        check_eq({tag, "_pcnew"}, bus.pc_new, 0);
        check_eq({tag, "_ovf"},   bus.stack_ovf, 0);
    endtask

    // One 8-phase machine cycle fetching word w; unused phases carry noise.
    task automatic drive_mc(input logic [7:0] w, input logic cond);
        for (int k = 0; k < 8; k++) begin
            bus.cycle      = 3'(k);
            bus.rom_data   = (k == 3) ? w[7:4] : (k == 4) ? w[3:0] : 4'($urandom);
            bus.pc_addr    = (k == 3) ? pc : 12'($urandom);
            bus.cond_taken = (k == 7) ? cond : 1'($urandom);
            #2;
            if (k == 3) begin
                ob_sw3   = bus.second_word;
                ob_stray = bus.instr_valid | bus.pc_load;
            end
            if (k == 7) begin
                ob_valid = bus.instr_valid;
                ob_load  = bus.pc_load;
                ob_new   = bus.pc_new;
                ob_opr   = bus.opr;
                ob_opa   = bus.opa;
                ob_opr2  = bus.opr2;
                ob_opa2  = bus.opa2;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Execute one instruction at the model pc and compare against the model.
    task automatic exec(input logic [7:0] w1, input logic [7:0] w2, input logic cond);
        logic [3:0]  o, a;
        logic        two, ld;
        logic [11:0] tgt, pc2;
        o   = w1[7:4];
        a   = w1[3:0];
        two = (o == 4'h1) || (o == 4'h4) || (o == 4'h5) || (o == 4'h7) ||
              (o == 4'h2 && a[0] == 1'b0);
        drive_mc(w1, cond);
        check_eq("sw_word1", ob_sw3, 0);
        check_eq("stray_word1", ob_stray, 0);
        check_eq("opr", ob_opr, o);
        check_eq("opa", ob_opa, a);
        check_eq("opr2_clr", ob_opr2, 0);
        check_eq("opa2_clr", ob_opa2, 0);
        if (!two) begin
            ld  = (o == 4'hC);
            tgt = 12'h000;  // empty pop only happens right after reset
            if (ld && stk.size() > 0) tgt = stk.pop_back();
            check_eq("valid_1w", ob_valid, 1);
            check_eq("load_1w", ob_load, ld);
            if (ld) check_eq("pcnew_bbl", ob_new, tgt);
            pc = ld ? tgt : pc + 12'd1;
        end else begin
            check_eq("valid_word1", ob_valid, 0);
            check_eq("load_word1", ob_load, 0);
            pc  = pc + 12'd1;
            pc2 = pc;
            drive_mc(w2, cond);
            check_eq("sw_word2", ob_sw3, 1);
            check_eq("stray_word2", ob_stray, 0);
            check_eq("opr_hold", ob_opr, o);
            check_eq("opa_hold", ob_opa, a);
            check_eq("opr2", ob_opr2, w2[7:4]);
            check_eq("opa2", ob_opa2, w2[3:0]);
            check_eq("valid_2w", ob_valid, 1);
            ld  = 1'b0;
            tgt = 12'h000;
            case (o)
                4'h4: begin ld = 1'b1; tgt = {a, w2}; end
                4'h5: begin
                    ld  = 1'b1;
                    tgt = {a, w2};
                    if (stk.size() == 3) begin
                        void'(stk.pop_front());
                        ovf_m = 1'b1;
                    end
                    stk.push_back(pc2 + 12'd1);
                end
                4'h1, 4'h7: if (cond) begin ld = 1'b1; tgt = {pc2[11:8], w2}; end
                default: ;
            endcase
            check_eq("load_2w", ob_load, ld);
            if (ld) check_eq("pcnew_2w", ob_new, tgt);
            pc = ld ? tgt : pc + 12'd1;
        end
        check_eq("stack_ovf", bus.stack_ovf, ovf_m);
    endtask

    initial begin
        logic [7:0] w1, w2;
        bus.cycle      = 3'd0;
        bus.rom_data   = 4'h0;
        bus.pc_addr    = 12'h000;
        bus.cond_taken = 1'b0;
        pc    = 12'h000;
        ovf_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Directed scenarios
        exec(8'hD5, 8'h00, 1'b0);                  // LDM 5
        pc = 12'h010; exec(8'h4A, 8'hBC, 1'b0);    // JUN 0xABC
        pc = 12'h0FE; exec(8'h52, 8'h34, 1'b0);    // JMS 0x234, ret 0x100
        exec(8'hC0, 8'h00, 1'b0);                  // BBL -> 0x100
        pc = 12'h3FE; exec(8'h14, 8'h7F, 1'b1);    // JCN taken -> 0x37F
        pc = 12'h3FE; exec(8'h14, 8'h7F, 1'b0);    // JCN not taken
        exec(8'h22, 8'h99, 1'b0);                  // FIM, no load
        exec(8'h21, 8'h00, 1'b0);                  // SRC, one word
        exec(8'h35, 8'h00, 1'b0);                  // JIN, no load
        pc = 12'h100;
        exec(8'h52, 8'h00, 1'b0);
        exec(8'h53, 8'h00, 1'b0);
        exec(8'h54, 8'h00, 1'b0);
        exec(8'h55, 8'h00, 1'b0);                  // 4th push overflows
        exec(8'hC0, 8'h00, 1'b0);
        exec(8'hC0, 8'h00, 1'b0);
        exec(8'hC0, 8'h00, 1'b0);
        exec(8'h53, 8'h21, 1'b0);                  // leave an entry on the stack

        // Asynchronous reset in the middle of a JUN second word
        drive_mc(8'h4A, 1'b0);
        for (int k = 0; k < 4; k++) begin
            bus.cycle = 3'(k);
            bus.rom_data = 4'($urandom);
            @(posedge clk);
            #1;
        end
        bus.cycle = 3'd4;
        bus.rom_data = 4'hB;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        bus.cycle = 3'd5;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.cycle = 3'd6;
        @(posedge clk);
        #1;
        bus.cycle = 3'd7;
        bus.cond_taken = 1'b1;
        #2;
        check_eq("partial_valid", bus.instr_valid, 0);
        check_eq("partial_load", bus.pc_load, 0);
        @(posedge clk);
        #1;
        stk.delete();
        ovf_m = 1'b0;
        exec(8'hD7, 8'h00, 1'b0);                  // first full fetch after release
        exec(8'hC0, 8'h00, 1'b0);                  // BBL on cleared stack -> 0x000

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            w1 = 8'($urandom);
            w2 = 8'($urandom);
            if (w1[7:4] == 4'hC && stk.size() == 0) w1[7:4] = 4'hD;
            exec(w1, w2, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
